// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory read port, redirect request and
// the decode-side valid/ready handshake.
interface fetch_if #(
    parameter int IMEM_WORDS = 64
);
    localparam int AW = $clog2(IMEM_WORDS);

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through a word-indexed instruction
// memory, queues fetched words in a 2-entry FIFO toward decode, halts on an
// all-zero instruction word and restarts on a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    fetch_if.master     bus,
    output logic        halted,
    output logic [31:0] retire_count
);
    localparam int AW = $clog2(IMEM_WORDS);
    // Byte-address bits that may be nonzero: the index field only, word aligned.
    localparam logic [31:0] PC_MASK = (32'(IMEM_WORDS) << 2) - 32'd4;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [1:0]  occ;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        fetch;
    logic        push;
    logic        pop;
    logic        halt_hit;

    // Next state and per-cycle fetch/push/pop decisions; redirect overrides all.
    always_comb begin
        state_nxt = state;
        fetch     = 1'b0;
        push      = 1'b0;
        halt_hit  = 1'b0;
        pop       = 1'b0;

        fetch    = (state == RUN) && (occ != 2'd2) && !bus.redirect_valid;
        push     = fetch && (bus.imem_rdata != 32'h0);
        halt_hit = fetch && (bus.imem_rdata == 32'h0);
        pop      = (occ != 2'd0) && bus.dec_ready && !bus.redirect_valid;

        if (bus.redirect_valid) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (halt_hit) state_nxt = HALT;
                default: state_nxt = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // PC: advances only when a word is actually queued, so a halting fetch
    // leaves it pointing at the zero word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pc <= RESET_PC & PC_MASK;
        else if (bus.redirect_valid) pc <= bus.redirect_pc & PC_MASK;
        else if (push)               pc <= (pc + 32'd4) & PC_MASK;
    end

    // FIFO control: pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (bus.redirect_valid) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage: data only, validity is tracked by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= pc;
        end
    end

    // Count of entries handed to decode; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   retire_count <= 32'd0;
        else if (pop) retire_count <= retire_count + 32'd1;
    end

    assign bus.imem_req  = fetch;
    assign bus.imem_addr = pc[AW+1:2];
    assign bus.dec_valid = (occ != 2'd0);
    assign bus.dec_instr = fifo_instr[rd_ptr];
    assign bus.dec_pc    = fifo_pc[rd_ptr];
    assign halted        = (state == HALT);
endmodule
